bldc_commutator: RTL and testbench

Six-step commutation and PWM sequencer for a three-phase brushless motor bridge. It converts a duty command, a direction bit and the Hall sensor code into per-phase high/low drive requests. Each request pair feeds one dead-time insertion stage (`nonoverlap`) ahead of the gate drivers. The block also sequences enable, coast-on-reversal, braking and Hall-fault shutdown, so the bridge never sees an illegal or abrupt drive change.

---
 rtl/bldc_commutator.sv | 182 ++++++++++++++++++
 tb/tb_bldc_commutator.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: PWM generation, Hall decode and enable/coast/brake/fault
// sequencing, producing registered per-phase high/low drive requests.
//
// state  | meaning
// IDLE   | drive disabled, all outputs off
// COAST  | all phases off for COAST_CYC cycles before driving
// RUN    | six-step commutation from Hall code and latched direction
// BRAKE  | all low sides on
// FAULT  | Hall fault latched, all off until drv_en drops
module bldc_commutator #(
    parameter int PWM_W        = 11,
    parameter int COAST_CYC    = 64,
    parameter int HALL_ERR_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             drv_en,
    input  logic [PWM_W-1:0] duty,
    input  logic             dir,
    input  logic             brake_n,
    input  logic [2:0]       hall,
    output logic             highA,
    output logic             lowA,
    output logic             highB,
    output logic             lowB,
    output logic             highC,
    output logic             lowC,
    output logic             pwm_synch,
    output logic             hall_fault
);

    localparam int CW = $clog2(COAST_CYC);
    localparam int EW = $clog2(HALL_ERR_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_COAST, S_RUN, S_BRAKE, S_FAULT} state_t;

    state_t           state_q;
    logic [PWM_W-1:0] cnt_q;
    logic [PWM_W-1:0] duty_lat_q;
    logic             pwm_synch_q;
    logic [2:0]       hall_s1_q;
    logic [2:0]       hall_s_q;
    logic             dir_lat_q;
    logic [CW-1:0]    coast_cnt_q;
    logic [EW-1:0]    hall_err_q;
    logic             hall_fault_q;
    logic [2:0]       high_q;
    logic [2:0]       low_q;

    logic [2:0]    fwd_pwm;
    logic [2:0]    fwd_low;
    logic [2:0]    pwm_ph;
    logic [2:0]    low_ph;
    logic          pwm;
    logic          hall_ok;
    logic [EW-1:0] hall_err_d;
    logic          fault_hit;
    logic [2:0]    high_d;
    logic [2:0]    low_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            duty_lat_q  <= '0;
            pwm_synch_q <= 1'b0;
            hall_s1_q   <= 3'b000;
            hall_s_q    <= 3'b000;
        end else begin
            cnt_q       <= cnt_q + PWM_W'(1);
            pwm_synch_q <= (cnt_q == '1);
            if (cnt_q == '1) duty_lat_q <= duty;
            hall_s1_q   <= hall;
            hall_s_q    <= hall_s1_q;
        end
    end

    // One-hot phase masks (bit0=A, bit1=B, bit2=C); illegal codes give empty masks.
    always_comb begin
        fwd_pwm = 3'b000;
        fwd_low = 3'b000;
        case (hall_s_q)
            3'b101: begin fwd_pwm = 3'b001; fwd_low = 3'b010; end
            3'b100: begin fwd_pwm = 3'b001; fwd_low = 3'b100; end
            3'b110: begin fwd_pwm = 3'b010; fwd_low = 3'b100; end
            3'b010: begin fwd_pwm = 3'b010; fwd_low = 3'b001; end
            3'b011: begin fwd_pwm = 3'b100; fwd_low = 3'b001; end
            3'b001: begin fwd_pwm = 3'b100; fwd_low = 3'b010; end
            default: ;
        endcase
        pwm_ph  = dir_lat_q ? fwd_pwm : fwd_low;
        low_ph  = dir_lat_q ? fwd_low : fwd_pwm;
        pwm     = cnt_q < duty_lat_q;
        hall_ok = |fwd_pwm;

        if (hall_ok)
            hall_err_d = '0;
        else if (hall_err_q >= EW'(HALL_ERR_MAX))
            hall_err_d = EW'(HALL_ERR_MAX);
        else
            hall_err_d = hall_err_q + EW'(1);
        fault_hit = !hall_ok && (hall_err_d >= EW'(HALL_ERR_MAX));

        high_d = 3'b000;
        low_d  = 3'b000;
        case (state_q)
            S_RUN: begin
                high_d = pwm_ph & {3{pwm}};
                low_d  = (pwm_ph & {3{~pwm}}) | low_ph;
            end
            S_BRAKE: low_d = 3'b111;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dir_lat_q    <= 1'b1;
            coast_cnt_q  <= '0;
            hall_err_q   <= '0;
            hall_fault_q <= 1'b0;
            high_q       <= 3'b000;
            low_q        <= 3'b000;
        end else begin
            high_q <= high_d;
            low_q  <= low_d;
            if (!drv_en) begin
                state_q      <= S_IDLE;
                hall_fault_q <= 1'b0;
                hall_err_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q     <= S_COAST;
                        dir_lat_q   <= dir;
                        coast_cnt_q <= '0;
                    end
                    S_COAST: begin
                        coast_cnt_q <= coast_cnt_q + CW'(1);
                        if (coast_cnt_q == CW'(COAST_CYC - 1))
                            state_q <= brake_n ? S_RUN : S_BRAKE;
                    end
                    S_RUN: begin
                        hall_err_q <= hall_err_d;
                        if (fault_hit) begin
                            state_q      <= S_FAULT;
                            hall_fault_q <= 1'b1;
                            hall_err_q   <= '0;
                        end else if (!brake_n) begin
                            state_q    <= S_BRAKE;
                            hall_err_q <= '0;
                        end else if (dir != dir_lat_q) begin
                            state_q     <= S_COAST;
                            dir_lat_q   <= dir;
                            coast_cnt_q <= '0;
                            hall_err_q  <= '0;
                        end
                    end
                    S_BRAKE: begin
                        if (brake_n) begin
                            state_q     <= S_COAST;
                            dir_lat_q   <= dir;
                            coast_cnt_q <= '0;
                        end
                    end
                    S_FAULT: ;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign highA      = high_q[0];
    assign highB      = high_q[1];
    assign highC      = high_q[2];
    assign lowA       = low_q[0];
    assign lowB       = low_q[1];
    assign lowC       = low_q[2];
    assign pwm_synch  = pwm_synch_q;
    assign hall_fault = hall_fault_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// Bench for bldc_commutator: directed sequence with randomized duty/Hall patterns, every
// cycle compared against a behavioural model driven by edge-indexed input histories.
module tb_bldc_commutator;

    localparam int P     = 2048;
    localparam int COAST = 64;
    localparam int EMAX  = 4;

    localparam int M_IDLE = 0, M_COAST = 1, M_RUN = 2, M_BRAKE = 3, M_FAULT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        drv_en;
    logic [10:0] duty;
    logic        dir;
    logic        brake_n;
    logic [2:0]  hall;
    logic        highA, lowA, highB, lowB, highC, lowC, pwm_synch, hall_fault;

    int checks = 0;
    int errors = 0;
    int k = 0;

    logic [2:0]  hall_hist [0:65535];
    logic [10:0] duty_hist [0:65535];

    int fwd_p [8] = '{-1, 2, 1, 2, 0, 0, 1, -1};
    int fwd_l [8] = '{-1, 1, 0, 0, 2, 1, 2, -1};
    logic [2:0] seq [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    int m_mode, m_remain, m_streak;
    bit m_dlat, m_fault;

    bldc_commutator #(.PWM_W(11), .COAST_CYC(COAST), .HALL_ERR_MAX(EMAX)) dut (
        .clk(clk), .rst_n(rst_n), .drv_en(drv_en), .duty(duty), .dir(dir),
        .brake_n(brake_n), .hall(hall),
        .highA(highA), .lowA(lowA), .highB(highB), .lowB(lowB), .highC(highC), .lowC(lowC),
        .pwm_synch(pwm_synch), .hall_fault(hall_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            if (errors <= 20)
                $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, k, got, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {highC, highB, highA, lowC, lowB, lowA};
    endfunction

    task automatic model_reset();
        k        = 0;
        m_mode   = M_IDLE;
        m_remain = 0;
        m_streak = 0;
        m_dlat   = 1'b1;
        m_fault  = 1'b0;
    endtask

    task automatic model_update(input logic [2:0] hs);
        if (!drv_en) begin
            m_mode  = M_IDLE;
            m_fault = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: begin m_mode = M_COAST; m_remain = COAST; m_dlat = dir; end
                M_COAST: begin
                    m_remain--;
                    if (m_remain == 0) m_mode = brake_n ? M_RUN : M_BRAKE;
                end
                M_RUN: begin
                    if (fwd_p[hs] < 0) m_streak = (m_streak < EMAX) ? m_streak + 1 : m_streak;
                    else m_streak = 0;
                    if (m_streak >= EMAX) begin m_mode = M_FAULT; m_fault = 1'b1; end
                    else if (!brake_n) m_mode = M_BRAKE;
                    else if (dir != m_dlat) begin m_mode = M_COAST; m_remain = COAST; m_dlat = dir; end
                end
                M_BRAKE: if (brake_n) begin m_mode = M_COAST; m_remain = COAST; m_dlat = dir; end
                default: ;
            endcase
        end
        if (m_mode != M_RUN) m_streak = 0;
    endtask

    task automatic tick();
        logic [2:0] hs, eh, el;
        logic [1:0] p, l;
        int dl, last;
        bit pw;
        @(posedge clk);
        k++;
        hall_hist[k] = hall;
        duty_hist[k] = duty;
        #1;
        hs   = (k >= 3) ? hall_hist[k-2] : 3'b000;
        last = ((k - 1) / P) * P;
        dl   = (last == 0) ? 0 : int'(duty_hist[last]);
        pw   = ((k - 1) % P) < dl;
        eh = 3'b000;
        el = 3'b000;
        if (m_mode == M_RUN && fwd_p[hs] >= 0) begin
            p = 2'(fwd_p[hs]);
            l = 2'(fwd_l[hs]);
            if (!m_dlat) begin p = 2'(fwd_l[hs]); l = 2'(fwd_p[hs]); end
            eh[p] = pw;
            el[p] = !pw;
            el[l] = 1'b1;
        end else if (m_mode == M_BRAKE) begin
            el = 3'b111;
        end
        chk("high", 32'({highC, highB, highA}), 32'(eh));
        chk("low", 32'({lowC, lowB, lowA}), 32'(el));
        chk("pwm_synch", 32'(pwm_synch), 32'((k % P) == 0));
        model_update(hs);
        chk("hall_fault", 32'(hall_fault), 32'(m_fault));
    endtask

    // Counts highA over one full period starting at the next pwm_synch.
    task automatic measure(output int hi);
        int g;
        g  = 0;
        hi = 0;
        while (!pwm_synch && g < 3 * P) begin tick(); g++; end
        for (int i = 0; i < P; i++) begin tick(); if (highA) hi++; end
    endtask

    task automatic count_zero(output int z);
        z = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (outs() == 6'd0) z++;
            else break;
        end
    endtask

    initial begin
        int hi, z;
        logic [2:0] lg;

        rst_n   = 1'b0;
        drv_en  = 1'b1;
        hall    = 3'b101;
        duty    = 11'd1024;
        dir     = 1'b1;
        brake_n = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 32'(outs()), 32'd0);
        chk("reset_synch", 32'(pwm_synch), 32'd0);
        chk("reset_fault", 32'(hall_fault), 32'd0);
        rst_n = 1'b1;

        repeat (COAST + 1) tick();
        chk("startup_quiet", 32'(outs()), 32'd0);
        tick();
        chk("startup_lowB", 32'(lowB), 32'd1);

        measure(hi);
        chk("duty_1024", 32'(hi), 32'd1024);
        hi = 0;
        for (int i = 0; i < P; i++) begin
            if (i == 300) duty = 11'd512;
            tick();
            if (highA) hi++;
        end
        chk("duty_change_same_period", 32'(hi), 32'd1024);
        measure(hi);
        chk("duty_512", 32'(hi), 32'd512);
        duty = 11'd0;
        tick();
        measure(hi);
        chk("duty_0", 32'(hi), 32'd0);
        duty = 11'd2047;
        tick();
        measure(hi);
        chk("duty_2047", 32'(hi), 32'd2047);

        for (int i = 0; i < 6; i++) begin
            hall = seq[i];
            duty = 11'($urandom_range(0, P - 1));
            repeat ($urandom_range(3, 30)) tick();
        end

        dir = 1'b0;
        tick();
        count_zero(z);
        chk("reverse_coast", 32'(z), 32'(COAST));
        for (int i = 0; i < 6; i++) begin
            hall = seq[i];
            duty = 11'($urandom_range(0, P - 1));
            repeat ($urandom_range(3, 30)) tick();
        end

        for (int i = 0; i < 12; i++) begin
            hall = seq[$urandom_range(0, 5)];
            duty = 11'($urandom_range(0, P - 1));
            repeat ($urandom_range(5, 25)) tick();
            if ($urandom_range(0, 1) == 1) begin
                hall = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        hall = 3'b110;
        repeat (6) tick();

        brake_n = 1'b0;
        dir     = 1'b1;
        repeat (2) tick();
        chk("brake_lows", 32'({lowC, lowB, lowA}), 32'h7);
        repeat (10) tick();
        brake_n = 1'b1;
        tick();
        count_zero(z);
        chk("brake_release_coast", 32'(z), 32'(COAST));
        repeat (20) tick();

        lg   = hall;
        hall = 3'b111;
        repeat (3) tick();
        hall = lg;
        repeat (10) tick();
        chk("three_illegal_no_fault", 32'(hall_fault), 32'd0);

        hall = 3'b111;
        repeat (4) tick();
        hall = lg;
        repeat (5) tick();
        chk("four_illegal_fault", 32'(hall_fault), 32'd1);
        repeat (20) tick();
        chk("fault_outs_off", 32'(outs()), 32'd0);
        drv_en = 1'b0;
        tick();
        chk("fault_cleared", 32'(hall_fault), 32'd0);
        drv_en = 1'b1;
        repeat (80) tick();

        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outs", 32'(outs()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (70) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
